element_delay_sequencer: RTL and testbench

//  Wraps one IncrementAndCompare core and walks it across the array. It seeds element 0, then for elements 1..NUM_ELEMENTS-1:
//  - accepts a comparator term from upstream;
//  - issues initiate to the core with fed-back operands;
//  - collects n_next, acks the core;
//  - streams the per-element delay downstream to the beamformer delay buffer.

---
 rtl/element_delay_sequencer_pkg.sv | 27 ++
 rtl/element_delay_sequencer_if.sv | 31 +++
 rtl/element_delay_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_element_delay_sequencer.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/element_delay_sequencer_pkg.sv
// Shared widths and FSM state type for the element delay sequencer.
// Every fixed-point field carries DwFractional fraction bits plus a sign or guard bit.
package element_delay_sequencer_pkg;

  localparam int unsigned NDwInteger       = 13;
  localparam int unsigned ADwInteger       = 3;
  localparam int unsigned IncTermDwInteger = 16;
  localparam int unsigned ErrorDwInteger   = 14;
  localparam int unsigned DwFractional     = 4;

  localparam int unsigned NW   = NDwInteger + DwFractional + 1;
  localparam int unsigned AW   = ADwInteger + DwFractional + 1;
  localparam int unsigned AsqW = 2 * ADwInteger + DwFractional + 1;
  localparam int unsigned TW   = IncTermDwInteger + DwFractional + 1;
  localparam int unsigned EW   = ErrorDwInteger + DwFractional + 1;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StWaitTerm,
    StIssue,
    StBusy,
    StEmit,
    StDone
  } seq_state_e;

endpackage

// File: rtl/element_delay_sequencer_if.sv
// Operand/result bundle between the sequencer (master) and one IncrementAndCompare core (slave).
interface element_delay_sequencer_if;
  import element_delay_sequencer_pkg::*;

  logic                   initiate;
  logic                   ack;
  logic                   rst;
  logic                   ready;
  logic [NW-1:0]          n_prev;
  logic [NW-1:0]          n_next;
  logic signed [AW-1:0]   a_prev;
  logic signed [AW-1:0]   a_next;
  logic [AsqW-1:0]        a_prev_sq;
  logic [AsqW-1:0]        a_next_sq;
  logic signed [TW-1:0]   comp_term;
  logic signed [TW-1:0]   comp_term_prev;
  logic signed [TW-1:0]   comp_term_next;
  logic signed [EW-1:0]   error_prev;
  logic signed [EW-1:0]   error_next;

  modport master (
    output initiate, ack, rst, n_prev, a_prev, a_prev_sq, comp_term, comp_term_prev, error_prev,
    input  ready, n_next, a_next, a_next_sq, comp_term_next, error_next
  );

  modport slave (
    input  initiate, ack, rst, n_prev, a_prev, a_prev_sq, comp_term, comp_term_prev, error_prev,
    output ready, n_next, a_next, a_next_sq, comp_term_next, error_next
  );

endinterface

// File: rtl/element_delay_sequencer.sv
// Walks one IncrementAndCompare core across the transducer array, seeding element 0 and
// streaming one delay beat per element to the beamformer delay buffer.
module element_delay_sequencer
  import element_delay_sequencer_pkg::*;
#(
  parameter int unsigned NumElements   = 64,
  parameter int unsigned MaxIterCycles = 32,
  localparam int unsigned IdxW = (NumElements > 1) ? $clog2(NumElements) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [NW-1:0]         n_init_i,
  input  logic signed [AW-1:0]  a_init_i,
  input  logic [AsqW-1:0]       a_init_sq_i,
  input  logic signed [TW-1:0]  comp_term_init_i,
  input  logic                  term_valid_i,
  input  logic signed [TW-1:0]  term_data_i,
  output logic                  term_ready_o,
  element_delay_sequencer_if.master core_io,
  output logic                  delay_valid_o,
  input  logic                  delay_ready_i,
  output logic [NW-1:0]         delay_out_o,
  output logic [IdxW-1:0]       delay_idx_o,
  output logic                  delay_last_o,
  output logic                  err_timeout_o,
  output logic                  busy_o
);

  localparam int unsigned WdogW = $clog2(MaxIterCycles) + 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(MaxIterCycles - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumElements - 1);

  seq_state_e state_q, state_d;

  // Feedback operands presented to the core for the next element.
  logic [NW-1:0]         n_q, n_d;
  logic signed [AW-1:0]  a_q, a_d;
  logic [AsqW-1:0]       asq_q, asq_d;
  logic signed [TW-1:0]  ctp_q, ctp_d;
  logic signed [EW-1:0]  err_q, err_d;
  logic signed [TW-1:0]  term_q, term_d;

  // Captured core result, held for the EMIT beat.
  logic [NW-1:0]         res_n_q, res_n_d;
  logic signed [AW-1:0]  res_a_q, res_a_d;
  logic [AsqW-1:0]       res_asq_q, res_asq_d;
  logic signed [TW-1:0]  res_ctp_q, res_ctp_d;
  logic signed [EW-1:0]  res_err_q, res_err_d;
  logic                  timed_out_q, timed_out_d;

  logic [IdxW-1:0]       idx_q, idx_d;
  logic [WdogW-1:0]      wdog_q, wdog_d;
  logic                  err_timeout_q, err_timeout_d;

  assign core_io.n_prev         = n_q;
  assign core_io.a_prev         = a_q;
  assign core_io.a_prev_sq      = asq_q;
  assign core_io.comp_term      = term_q;
  assign core_io.comp_term_prev = ctp_q;
  assign core_io.error_prev     = err_q;

  assign err_timeout_o = err_timeout_q;
  assign busy_o        = (state_q != StIdle) && (state_q != StDone);

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    a_d           = a_q;
    asq_d         = asq_q;
    ctp_d         = ctp_q;
    err_d         = err_q;
    term_d        = term_q;
    res_n_d       = res_n_q;
    res_a_d       = res_a_q;
    res_asq_d     = res_asq_q;
    res_ctp_d     = res_ctp_q;
    res_err_d     = res_err_q;
    timed_out_d   = timed_out_q;
    idx_d         = idx_q;
    wdog_d        = wdog_q;
    err_timeout_d = err_timeout_q;

    term_ready_o     = 1'b0;
    core_io.initiate = 1'b0;
    core_io.ack      = 1'b0;
    core_io.rst      = 1'b0;
    delay_valid_o    = 1'b0;
    delay_out_o      = '0;
    delay_idx_o      = '0;
    delay_last_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d       = StSeed;
          n_d           = n_init_i;
          a_d           = a_init_i;
          asq_d         = a_init_sq_i;
          ctp_d         = comp_term_init_i;
          err_d         = '0;
          idx_d         = '0;
          err_timeout_d = 1'b0;
        end
      end
      StSeed: begin
        delay_valid_o = 1'b1;
        delay_out_o   = n_q;
        delay_idx_o   = idx_q;
        delay_last_o  = (idx_q == IdxLast);
        if (delay_ready_i) begin
          idx_d   = idx_q + IdxW'(1);
          state_d = delay_last_o ? StDone : StWaitTerm;
        end
      end
      StWaitTerm: begin
        term_ready_o = 1'b1;
        if (term_valid_i) begin
          term_d  = term_data_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        core_io.initiate = 1'b1;
        wdog_d           = '0;
        state_d          = StBusy;
      end
      StBusy: begin
        if (core_io.ready) begin
          res_n_d     = core_io.n_next;
          res_a_d     = core_io.a_next;
          res_asq_d   = core_io.a_next_sq;
          res_ctp_d   = core_io.comp_term_next;
          res_err_d   = core_io.error_next;
          timed_out_d = 1'b0;
          state_d     = StEmit;
        end else if (wdog_q == WdogLast) begin
          // Core is stuck: reset it and repeat the previous element's delay.
          core_io.rst   = 1'b1;
          err_timeout_d = 1'b1;
          res_n_d       = n_q;
          timed_out_d   = 1'b1;
          state_d       = StEmit;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
        end
      end
      StEmit: begin
        delay_valid_o = 1'b1;
        delay_out_o   = res_n_q;
        delay_idx_o   = idx_q;
        delay_last_o  = (idx_q == IdxLast);
        if (delay_ready_i) begin
          core_io.ack = !timed_out_q;
          if (!timed_out_q) begin
            n_d   = res_n_q;
            a_d   = res_a_q;
            asq_d = res_asq_q;
            ctp_d = res_ctp_q;
            err_d = res_err_q;
          end
          idx_d   = idx_q + IdxW'(1);
          state_d = delay_last_o ? StDone : StWaitTerm;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      n_q           <= '0;
      a_q           <= '0;
      asq_q         <= '0;
      ctp_q         <= '0;
      err_q         <= '0;
      term_q        <= '0;
      res_n_q       <= '0;
      res_a_q       <= '0;
      res_asq_q     <= '0;
      res_ctp_q     <= '0;
      res_err_q     <= '0;
      timed_out_q   <= 1'b0;
      idx_q         <= '0;
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      a_q           <= a_d;
      asq_q         <= asq_d;
      ctp_q         <= ctp_d;
      err_q         <= err_d;
      term_q        <= term_d;
      res_n_q       <= res_n_d;
      res_a_q       <= res_a_d;
      res_asq_q     <= res_asq_d;
      res_ctp_q     <= res_ctp_d;
      res_err_q     <= res_err_d;
      timed_out_q   <= timed_out_d;
      idx_q         <= idx_d;
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_element_delay_sequencer.sv
// Bench for element_delay_sequencer: behavioural core model with programmable latency and a
// scoreboard of expected delay beats popped on every downstream handshake.
module tb_element_delay_sequencer;
  import element_delay_sequencer_pkg::*;

  localparam int unsigned NumEl = 4;
  localparam int unsigned IdxW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic                 rst_n;
  logic                 start, start1;
  logic [NW-1:0]        n_init;
  logic signed [AW-1:0] a_init;
  logic [AsqW-1:0]      a_init_sq;
  logic signed [TW-1:0] comp_term_init, term_data;
  logic                 term_valid, term_ready, term_ready1;
  logic                 delay_valid, delay_ready, delay_last, err_timeout, busy;
  logic                 delay_valid1, delay_ready1, delay_last1, err_timeout1, busy1;
  logic [NW-1:0]        delay_out, delay_out1;
  logic [IdxW-1:0]      delay_idx;
  logic [0:0]           delay_idx1;

  element_delay_sequencer_if cif ();
  element_delay_sequencer_if cif1 ();

  element_delay_sequencer #(.NumElements(NumEl), .MaxIterCycles(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .n_init_i(n_init), .a_init_i(a_init),
    .a_init_sq_i(a_init_sq), .comp_term_init_i(comp_term_init), .term_valid_i(term_valid),
    .term_data_i(term_data), .term_ready_o(term_ready), .core_io(cif),
    .delay_valid_o(delay_valid), .delay_ready_i(delay_ready), .delay_out_o(delay_out),
    .delay_idx_o(delay_idx), .delay_last_o(delay_last), .err_timeout_o(err_timeout),
    .busy_o(busy)
  );

  element_delay_sequencer #(.NumElements(1), .MaxIterCycles(32)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .n_init_i(n_init), .a_init_i(a_init),
    .a_init_sq_i(a_init_sq), .comp_term_init_i(comp_term_init), .term_valid_i(term_valid),
    .term_data_i(term_data), .term_ready_o(term_ready1), .core_io(cif1),
    .delay_valid_o(delay_valid1), .delay_ready_i(delay_ready1), .delay_out_o(delay_out1),
    .delay_idx_o(delay_idx1), .delay_last_o(delay_last1), .err_timeout_o(err_timeout1),
    .busy_o(busy1)
  );

  assign cif1.ready          = 1'b0;
  assign cif1.n_next         = '0;
  assign cif1.a_next         = '0;
  assign cif1.a_next_sq      = '0;
  assign cif1.comp_term_next = '0;
  assign cif1.error_next     = '0;

  // Behavioural core: ready rises lat cycles after initiate, drops on ack or core reset.
  int         lat = 3;
  bit         never = 1'b0;
  logic       m_ready;
  int         m_cnt;
  bit         m_pend;
  logic [1:0] m_k;
  logic [NW-1:0] n_tbl [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b0;
      m_pend  <= 1'b0;
      m_cnt   <= 0;
      m_k     <= 2'd0;
    end else begin
      if (start) m_k <= 2'd0;
      if (cif.rst) begin
        m_ready <= 1'b0;
        m_pend  <= 1'b0;
      end else if (cif.initiate) begin
        m_pend <= 1'b1;
        m_cnt  <= lat;
      end else if (m_pend && !m_ready && !never) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt <= 1) m_ready <= 1'b1;
      end else if (m_ready && cif.ack) begin
        m_ready <= 1'b0;
        m_pend  <= 1'b0;
        m_k     <= m_k + 2'd1;
      end
    end
  end

  assign cif.ready          = m_ready;
  assign cif.n_next         = n_tbl[m_k];
  assign cif.a_next         = AW'(m_k) + AW'(1);
  assign cif.a_next_sq      = AsqW'(m_k);
  assign cif.comp_term_next = cif.comp_term;
  assign cif.error_next     = EW'(3);

  typedef struct packed {
    logic [NW-1:0]   n;
    logic [IdxW-1:0] idx;
    logic            last;
  } beat_t;

  beat_t            exp_q[$];
  logic [NW-1:0]    ini_n[$];
  logic [EW-1:0]    ini_e[$];
  logic [TW-1:0]    ini_t[$];
  logic [AW-1:0]    ini_a[$];
  int               ack_cnt = 0;
  int               rst_cnt = 0;
  bit               ack_prev = 1'b0;
  bit               init1_seen = 1'b0;

  function automatic void push_beat(input logic [NW-1:0] n, input int idx);
    beat_t b;
    b.n    = n;
    b.idx  = IdxW'(idx);
    b.last = (idx == NumEl - 1);
    exp_q.push_back(b);
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && delay_valid && delay_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: got n=%h idx=%0d last=%0b, required no beat",
                 delay_out, delay_idx, delay_last);
      end else begin
        e = exp_q.pop_front();
        if ({delay_out, delay_idx, delay_last} !== e) begin
          fails++;
          $display("FAIL beat: got n=%h idx=%0d last=%0b, required n=%h idx=%0d last=%0b",
                   delay_out, delay_idx, delay_last, e.n, e.idx, e.last);
        end
      end
    end
    if (rst_n && cif.ack) begin
      ack_cnt++;
      tests++;
      if (!(delay_valid && delay_ready) || ack_prev) begin
        fails++;
        $display("FAIL ack_pulse: got ack with valid=%0b ready=%0b prev_ack=%0b, required a 1-cycle ack on handshake",
                 delay_valid, delay_ready, ack_prev);
      end
    end
    ack_prev = cif.ack;
    if (rst_n && cif.initiate) begin
      ini_n.push_back(cif.n_prev);
      ini_e.push_back(cif.error_prev);
      ini_t.push_back(cif.comp_term);
      ini_a.push_back(cif.a_prev);
    end
    if (rst_n && cif.rst) rst_cnt++;
    if (cif1.initiate) init1_seen = 1'b1;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, delay_valid, delay_out, delay_idx, delay_last, err_timeout, term_ready,
         cif.initiate, cif.ack, cif.rst, cif.n_prev, cif.error_prev} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%0b valid=%0b out=%h init=%0b, required all 0",
               busy, delay_valid, delay_out, cif.initiate);
    end
    tests++;
    if ({busy1, delay_valid1, delay_out1, delay_last1, term_ready1} !== '0) begin
      fails++;
      $display("FAIL reset_outputs_single: got busy=%0b valid=%0b out=%h, required all 0",
               busy1, delay_valid1, delay_out1);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single_element();
    delay_ready1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    tests++;
    if ({delay_valid1, delay_out1, delay_idx1, delay_last1} !== {1'b1, 18'h00A00, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL single_beat: got valid=%0b out=%h idx=%0d last=%0b, required 1 00a00 0 1",
               delay_valid1, delay_out1, delay_idx1, delay_last1);
    end
    repeat (10) @(negedge clk);
    tests++;
    if (init1_seen || busy1 || delay_valid1) begin
      fails++;
      $display("FAIL single_no_core: got initiate_seen=%0b busy=%0b valid=%0b, required 0 0 0",
               init1_seen, busy1, delay_valid1);
    end
  endtask

  task automatic test_stream();
    bit ok;
    lat = 3; never = 1'b0; term_valid = 1'b1; term_data = 21'sh00123; delay_ready = 1'b1;
    ini_n.delete(); ini_e.delete(); ini_t.delete(); ini_a.delete();
    ack_cnt = 0;
    push_beat(18'h00A00, 0); push_beat(18'h00A10, 1);
    push_beat(18'h00A28, 2); push_beat(18'h00A48, 3);
    pulse_start();
    @(negedge clk);
    tests++;
    if (delay_valid !== 1'b1 || delay_out !== 18'h00A00) begin
      fails++;
      $display("FAIL seed_latency: got valid=%0b out=%h, required 1 00a00", delay_valid, delay_out);
    end
    wait_idle(300, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL stream_done: got busy=%0b pending=%0d, required idle with 0 pending",
               busy, exp_q.size());
    end
    tests++;
    if (ini_n.size() != 3) begin
      fails++;
      $display("FAIL stream_initiates: got %0d, required 3", ini_n.size());
    end else begin
      tests++;
      if (ini_n[1] !== 18'h00A10 || ini_e[1] !== 19'h00003) begin
        fails++;
        $display("FAIL feedback_2nd: got n_prev=%h err_prev=%h, required 00a10 00003",
                 ini_n[1], ini_e[1]);
      end
      tests++;
      if (ini_n[0] !== 18'h00A00 || ini_e[0] !== 19'h0 || ini_a[0] !== 8'h05 ||
          ini_a[1] !== 8'h01 || ini_t[0] !== 21'h00123) begin
        fails++;
        $display("FAIL operands: got n0=%h e0=%h a0=%h a1=%h t0=%h, required 00a00 0 05 01 00123",
                 ini_n[0], ini_e[0], ini_a[0], ini_a[1], ini_t[0]);
      end
    end
    tests++;
    if (ack_cnt != 3 || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL stream_acks: got acks=%0d err_timeout=%0b, required 3 0", ack_cnt, err_timeout);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    lat = 2; term_valid = 1'b1; delay_ready = 1'b0; ack_cnt = 0;
    push_beat(18'h00A00, 0); push_beat(18'h00A10, 1);
    push_beat(18'h00A28, 2); push_beat(18'h00A48, 3);
    pulse_start();
    for (int b = 0; b < 4; b++) begin
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (delay_valid) begin
          seen = 1'b1;
          break;
        end
      end
      tests++;
      if (!seen) begin
        fails++;
        $display("FAIL bp_valid_timeout: got no beat %0d, required a beat", b);
        break;
      end
      if (b == 1) begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          tests++;
          if (delay_out !== 18'h00A10 || delay_idx !== 2'd1 || cif.ack !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold: got out=%h idx=%0d ack=%0b, required 00a10 1 0",
                     delay_out, delay_idx, cif.ack);
          end
        end
      end
      @(posedge clk); #1 delay_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (cif.ack !== (b != 0)) begin
        fails++;
        $display("FAIL bp_ack_on_ready: got ack=%0b, required %0b", cif.ack, (b != 0));
      end
      @(posedge clk); #1 delay_ready = 1'b0;
    end
    delay_ready = 1'b1;
    wait_idle(100, ok);
    tests++;
    if (!ok || ack_cnt != 3) begin
      fails++;
      $display("FAIL bp_done: got idle=%0b acks=%0d, required 1 3", ok, ack_cnt);
    end
  endtask

  task automatic test_term_stall();
    bit ok;
    bit seen;
    lat = 1; term_valid = 1'b0; delay_ready = 1'b1;
    push_beat(18'h00A00, 0); push_beat(18'h00A10, 1);
    push_beat(18'h00A28, 2); push_beat(18'h00A48, 3);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (term_ready) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL stall_term_ready: got term_ready=0, required 1");
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests++;
      if (cif.initiate !== 1'b0 || term_ready !== 1'b1) begin
        fails++;
        $display("FAIL stall_no_initiate: got initiate=%0b term_ready=%0b, required 0 1",
                 cif.initiate, term_ready);
      end
    end
    @(posedge clk); #1 term_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (cif.initiate !== 1'b1) begin
      fails++;
      $display("FAIL stall_initiate_after_accept: got %0b, required 1", cif.initiate);
    end
    wait_idle(200, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL stall_done: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    int cnt;
    never = 1'b1; term_valid = 1'b1; delay_ready = 1'b1; ack_cnt = 0; rst_cnt = 0;
    for (int i = 0; i < 4; i++) push_beat(18'h00A00, i);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cif.initiate) begin
        seen = 1'b1;
        break;
      end
    end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (cif.rst) break;
    end
    tests++;
    if (!seen || cnt != 32) begin
      fails++;
      $display("FAIL wdog_cycles: got initiate_seen=%0b cycles=%0d, required 1 32", seen, cnt);
    end
    @(negedge clk);
    tests++;
    if (cif.rst !== 1'b0 || err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL wdog_pulse: got core_rst=%0b err_timeout=%0b, required 0 1", cif.rst, err_timeout);
    end
    wait_idle(400, ok);
    tests++;
    if (!ok || ack_cnt != 0 || rst_cnt != 3 || err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL wdog_scan: got idle=%0b acks=%0d core_rsts=%0d err_timeout=%0b, required 1 0 3 1",
               ok, ack_cnt, rst_cnt, err_timeout);
    end
    never = 1'b0;
  endtask

  task automatic test_reset_midscan();
    bit ok;
    bit seen;
    lat = 20; never = 1'b0; term_valid = 1'b1; delay_ready = 1'b1;
    push_beat(18'h00A00, 0);
    pulse_start();
    @(negedge clk);
    tests++;
    if (err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL err_clear_on_start: got %0b, required 0", err_timeout);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cif.initiate) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    tests++;
    if (!seen || busy !== 1'b1) begin
      fails++;
      $display("FAIL midscan_busy: got initiate_seen=%0b busy=%0b, required 1 1", seen, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, delay_valid, delay_out, delay_idx, delay_last, err_timeout, term_ready,
         cif.initiate, cif.ack, cif.rst, cif.n_prev} !== '0) begin
      fails++;
      $display("FAIL async_reset: got busy=%0b valid=%0b n_prev=%h, required all 0",
               busy, delay_valid, cif.n_prev);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lat = 3;
    push_beat(18'h00A00, 0); push_beat(18'h00A10, 1);
    push_beat(18'h00A28, 2); push_beat(18'h00A48, 3);
    pulse_start();
    @(negedge clk);
    tests++;
    if (delay_valid !== 1'b1 || delay_idx !== 2'd0) begin
      fails++;
      $display("FAIL restart_idx: got valid=%0b idx=%0d, required 1 0", delay_valid, delay_idx);
    end
    wait_idle(300, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL restart_done: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    n_tbl[0] = 18'h00A10;
    n_tbl[1] = 18'h00A28;
    n_tbl[2] = 18'h00A48;
    n_tbl[3] = 18'h00000;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    n_init = 18'h00A00; a_init = 8'sd5; a_init_sq = 11'd25; comp_term_init = 21'sd7;
    term_valid = 1'b0; term_data = '0; delay_ready = 1'b0; delay_ready1 = 1'b0;
    test_reset();
    test_single_element();
    test_stream();
    test_backpressure();
    test_term_stall();
    test_timeout();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
